// File: rtl/y_ram_writer_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : y_ram_writer_pkg
// Brief   : Shared sizes, types and helpers for the activation-store writer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
package y_ram_writer_pkg;

  localparam int MAX_NEURONS = 8;
  localparam int MAX_DEPTH   = 4;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic word_t clamp_count(input word_t count, input word_t limit);
    return (count > limit) ? limit : count;
  endfunction

endpackage
`default_nettype wire

// File: rtl/y_ram_writer_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : y_ram_writer_if
// Brief   : Result handshake, read request and store-side bus of the writer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
interface y_ram_writer_if
  import y_ram_writer_pkg::*;
#(
  parameter int N_NEURONS = MAX_NEURONS
);
  logic                       res_valid;
  logic                       res_ready;
  word_t                      res_layer;
  word_t                      res_count;
  logic [N_NEURONS-1:0][31:0] res_vec;
  logic                       rd_req;
  word_t                      rd_layer;
  logic                       rd_grant;
  logic                       rw;
  word_t                      layer_index;
  word_t                      neuron_index;
  word_t                      y_in;
  logic                       busy;
  logic                       done;
  logic                       err;

  // master: compute engine / read requester side; slave: the writer itself
  modport master (
    output res_valid, res_layer, res_count, res_vec, rd_req, rd_layer,
    input  res_ready, rd_grant, rw, layer_index, neuron_index, y_in, busy, done, err
  );

  modport slave (
    input  res_valid, res_layer, res_count, res_vec, rd_req, rd_layer,
    output res_ready, rd_grant, rw, layer_index, neuron_index, y_in, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/y_ram_writer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : y_ram_writer
// Brief   : Serialises one captured layer result into per-neuron store writes.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module y_ram_writer
  import y_ram_writer_pkg::*;
#(
  parameter int N_NEURONS = MAX_NEURONS,
  parameter int DEPTH     = MAX_DEPTH
) (
  input  wire logic      CLK,
  input  wire logic      RST_N,
  y_ram_writer_if.slave  bus
);

  localparam int    c_KW    = (N_NEURONS > 2) ? $clog2(N_NEURONS) : 1;
  localparam word_t c_LAST  = word_t'(N_NEURONS - 1);
  localparam word_t c_DEPTH = word_t'(DEPTH);

  state_t                     r_state;
  logic [N_NEURONS-1:0][31:0] r_vec;
  word_t                      r_cnt;
  logic [c_KW-1:0]            r_k;
  logic                       r_res_ready;
  logic                       r_rd_grant;
  logic                       r_rw;
  word_t                      r_layer_index;
  word_t                      r_neuron_index;
  word_t                      r_y_in;
  logic                       r_busy;
  logic                       r_done;
  logic                       r_err;

  logic  w_hs;
  logic  w_bad_layer;
  word_t w_cnt;

  // r_res_ready is only ever set while IDLE, so it alone qualifies the handshake
  assign w_hs        = bus.res_valid && r_res_ready;
  assign w_bad_layer = (bus.res_layer == '0) || (bus.res_layer >= c_DEPTH);
  assign w_cnt       = clamp_count(bus.res_count, c_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state        <= ST_IDLE;
      r_vec          <= '0;
      r_cnt          <= '0;
      r_k            <= '0;
      r_res_ready    <= 1'b0;
      r_rd_grant     <= 1'b0;
      r_rw           <= 1'b0;
      r_layer_index  <= '0;
      r_neuron_index <= '0;
      r_y_in         <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rd_grant <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_res_ready <= 1'b1;
          r_rw        <= 1'b0;
          r_busy      <= 1'b0;
          if (w_hs) begin
            if (w_bad_layer) begin
              r_err <= 1'b1;
            end else begin
              r_vec       <= bus.res_vec;
              r_cnt       <= w_cnt;
              r_res_ready <= 1'b0;
              if (w_cnt == '0) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end else begin
                // first write issued straight from the input so it lands on the next cycle
                r_state        <= ST_WRITE;
                r_busy         <= 1'b1;
                r_rw           <= 1'b1;
                r_layer_index  <= bus.res_layer;
                r_neuron_index <= '0;
                r_y_in         <= bus.res_vec[0];
                r_k            <= c_KW'(1);
              end
            end
          end else if (bus.rd_req) begin
            r_layer_index <= bus.rd_layer;
            r_rd_grant    <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (word_t'(r_k) >= r_cnt) begin
            r_state <= ST_DONE;
            r_rw    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_neuron_index <= word_t'(r_k);
            r_y_in         <= r_vec[r_k];
            r_k            <= r_k + 1'b1;
          end
        end
        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_res_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.res_ready    = r_res_ready;
  assign bus.rd_grant     = r_rd_grant;
  assign bus.rw           = r_rw;
  assign bus.layer_index  = r_layer_index;
  assign bus.neuron_index = r_neuron_index;
  assign bus.y_in         = r_y_in;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_y_ram_writer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_y_ram_writer
// Brief   : Directed bench for y_ram_writer with a behavioural activation store.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_y_ram_writer;

  localparam int N = 8;
  localparam int D = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   n_writes;
  int   n_done;
  int   n_bias_wr;
  int   w_base;

  logic [31:0] store [0:D-1][0:N-1];

  y_ram_writer_if #(.N_NEURONS(N)) bus ();

  y_ram_writer #(.N_NEURONS(N), .DEPTH(D)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // store model: latches whatever write is presented during the cycle
  always @(negedge clk) begin
    if (bus.rw === 1'b1) begin
      n_writes = n_writes + 1;
      if (bus.neuron_index == 32'(N - 1)) n_bias_wr = n_bias_wr + 1;
      else store[bus.layer_index[1:0]][bus.neuron_index[2:0]] = bus.y_in;
    end
    if (bus.done === 1'b1) n_done = n_done + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    assert (obs === exp) else begin
      n_err = n_err + 1;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_vec(input int base);
    for (int i = 0; i < N; i++) bus.res_vec[i] = 32'(base + i);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; n_writes = 0; n_done = 0; n_bias_wr = 0;
    for (int l = 0; l < D; l++)
      for (int i = 0; i < N; i++) store[l][i] = (i == N - 1) ? 32'd1 : 32'd0;
    rst_n = 1'b0;
    bus.res_valid = 1'b0; bus.res_layer = '0; bus.res_count = '0; bus.res_vec = '0;
    bus.rd_req = 1'b0; bus.rd_layer = '0;

    // reset state
    tick(); tick();
    chk("rst_rw", bus.rw, 0);
    chk("rst_layer", bus.layer_index, 0);
    chk("rst_nidx", bus.neuron_index, 0);
    chk("rst_y", bus.y_in, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_grant", bus.rd_grant, 0);
    chk("rst_ready", bus.res_ready, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("rel_ready", bus.res_ready, 1);

    // basic 3-neuron layer, inputs scrambled after the handshake
    load_vec(5);
    bus.res_layer = 2; bus.res_count = 3; bus.res_valid = 1'b1;
    w_base = n_writes;
    tick();
    bus.res_valid = 1'b0; load_vec(99); bus.res_layer = 3;
    chk("t1_rw0", bus.rw, 1);
    chk("t1_layer0", bus.layer_index, 2);
    chk("t1_nidx0", bus.neuron_index, 0);
    chk("t1_y0", bus.y_in, 5);
    chk("t1_busy", bus.busy, 1);
    chk("t1_ready0", bus.res_ready, 0);
    tick();
    chk("t1_nidx1", bus.neuron_index, 1);
    chk("t1_y1", bus.y_in, 6);
    tick();
    chk("t1_nidx2", bus.neuron_index, 2);
    chk("t1_y2", bus.y_in, 7);
    chk("t1_layer2", bus.layer_index, 2);
    tick();
    chk("t1_done", bus.done, 1);
    chk("t1_rw_off", bus.rw, 0);
    chk("t1_busy_off", bus.busy, 0);
    chk("t1_ready_done", bus.res_ready, 0);
    tick();
    chk("t1_done_pulse", bus.done, 0);
    chk("t1_ready_back", bus.res_ready, 1);
    chk("t1_nwrites", n_writes - w_base, 3);

    // zero-count layer goes straight to done
    bus.res_layer = 1; bus.res_count = 0; bus.res_valid = 1'b1;
    w_base = n_writes;
    tick();
    bus.res_valid = 1'b0;
    chk("t6_done", bus.done, 1);
    chk("t6_rw", bus.rw, 0);
    chk("t6_ready", bus.res_ready, 0);
    tick();
    chk("t6_done_off", bus.done, 0);
    chk("t6_ready_back", bus.res_ready, 1);
    chk("t6_nwrites", n_writes - w_base, 0);

    // oversize count is clamped below the bias slot
    load_vec(100);
    bus.res_layer = 3; bus.res_count = 20; bus.res_valid = 1'b1;
    w_base = n_writes;
    tick();
    bus.res_valid = 1'b0;
    for (int i = 0; i < N - 1; i++) begin
      chk($sformatf("t2_nidx%0d", i), bus.neuron_index, 32'(i));
      chk($sformatf("t2_y%0d", i), bus.y_in, 32'(100 + i));
      tick();
    end
    chk("t2_done", bus.done, 1);
    tick();
    chk("t2_ready_back", bus.res_ready, 1);
    chk("t2_nwrites", n_writes - w_base, 7);
    chk("t2_bias_writes", n_bias_wr, 0);
    chk("t2_store_bias", store[3][7], 1);
    chk("t2_store6", store[3][6], 106);

    // illegal layers rejected
    bus.res_layer = 0; bus.res_count = 2; bus.res_valid = 1'b1;
    w_base = n_writes;
    tick();
    chk("t3_err_l0", bus.err, 1);
    chk("t3_ready_l0", bus.res_ready, 1);
    bus.res_layer = 4;
    tick();
    bus.res_valid = 1'b0;
    chk("t3_err_l4", bus.err, 1);
    chk("t3_rw_l4", bus.rw, 0);
    chk("t3_ready_l4", bus.res_ready, 1);
    tick();
    chk("t3_err_pulse", bus.err, 0);
    chk("t3_nwrites", n_writes - w_base, 0);

    // read forwarding, and read held off by a write sequence
    bus.rd_req = 1'b1; bus.rd_layer = 3;
    tick();
    chk("t4_grant", bus.rd_grant, 1);
    chk("t4_rw", bus.rw, 0);
    chk("t4_layer", bus.layer_index, 3);
    load_vec(200);
    bus.res_layer = 1; bus.res_count = 2; bus.res_valid = 1'b1;
    tick();
    bus.res_valid = 1'b0;
    chk("t4_prio_grant", bus.rd_grant, 0);
    chk("t4_prio_rw", bus.rw, 1);
    chk("t4_prio_layer", bus.layer_index, 1);
    chk("t4_y0", bus.y_in, 200);
    tick();
    chk("t4_wr_grant", bus.rd_grant, 0);
    chk("t4_y1", bus.y_in, 201);
    tick();
    chk("t4_done", bus.done, 1);
    chk("t4_done_grant", bus.rd_grant, 0);
    tick();
    chk("t4_idle1_grant", bus.rd_grant, 0);
    tick();
    chk("t4_regrant", bus.rd_grant, 1);
    chk("t4_regrant_layer", bus.layer_index, 3);
    bus.rd_req = 1'b0;
    tick();

    // reset in the middle of a write sequence
    load_vec(50);
    bus.res_layer = 2; bus.res_count = 5; bus.res_valid = 1'b1;
    tick();
    bus.res_valid = 1'b0;
    chk("t5_y0", bus.y_in, 50);
    tick();
    chk("t5_y1", bus.y_in, 51);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_rw", bus.rw, 0);
    chk("t5_rst_nidx", bus.neuron_index, 0);
    chk("t5_rst_y", bus.y_in, 0);
    chk("t5_rst_busy", bus.busy, 0);
    chk("t5_rst_ready", bus.res_ready, 0);
    tick(); tick();
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("t5_rel_ready", bus.res_ready, 1);
    chk("t5_rel_done", bus.done, 0);
    chk("t5_rel_rw", bus.rw, 0);
    tick(); tick();
    chk("t5_store0", store[2][0], 50);
    chk("t5_store1", store[2][1], 51);
    chk("t5_store2", store[2][2], 7);
    chk("t5_done_total", n_done, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
